display_scan_ctrl: RTL

//  Time-multiplexes the 28-bit, 4-digit segment bus from the hex-to-7-seg converter onto one

---
 rtl/disp_pkg.sv | 33 +++
 rtl/display_scan_ctrl_scan_timer.sv | 27 ++
 rtl/display_scan_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared constants, state encoding and helpers for the 7-segment scan controller.
// The optional DISP_BRIGHT_EN build adds PWM dimming inside display_scan_ctrl.
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned SEL_W      = 2;

  localparam logic [SEG_W-1:0]      SEG_OFF = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = '1;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  // Width that holds N-1 for the longer of the two intervals.
  function automatic int unsigned timer_width(int unsigned a, int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // Active-low one-cold anode pattern for a digit index.
  function automatic logic [NUM_DIGITS-1:0] anode_sel(logic [SEL_W-1:0] idx);
    logic [NUM_DIGITS-1:0] a;
    a      = '1;
    a[idx] = 1'b0;
    return a;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// Loadable down-counter shared by the BLANK and DRIVE intervals; terminal is
// high while the count sits at zero, so a load of N-1 yields an N-cycle interval.
module scan_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         terminal
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign terminal = (count == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexes four latched 7-segment words onto one cathode bus with blanking gaps.
// Define DISP_BRIGHT_EN to add the 3-bit bright input (8-slice anode PWM in DRIVE).
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned DIGIT_TICKS = 100000,
  parameter int unsigned BLANK_TICKS = 1000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NUM_DIGITS*SEG_W-1:0] display,
`ifdef DISP_BRIGHT_EN
  input  logic [2:0]                  bright,
`endif
  output logic [SEG_W-1:0]            seg,
  output logic [NUM_DIGITS-1:0]       an,
  output logic [SEL_W-1:0]            digit_sel,
  output logic                        frame_done
);

  localparam int unsigned TW = timer_width(DIGIT_TICKS, BLANK_TICKS);
  localparam logic [TW-1:0] DRIVE_LOAD = TW'(DIGIT_TICKS - 1);
  localparam logic [TW-1:0] BLANK_LOAD = TW'(BLANK_TICKS - 1);

  state_t                             state;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]   frame;
  logic [TW-1:0]                      count;
  logic [TW-1:0]                      load_val;
  logic                               terminal;
  logic                               load;
  logic                               clear;
  logic                               drive_on;

  scan_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .terminal (terminal)
  );

  // Reload on every state entry: IDLE->BLANK, BLANK->DRIVE, DRIVE->BLANK.
  always_comb begin
    clear    = !enable;
    load     = (state == IDLE) || terminal;
    load_val = (state == BLANK) ? DRIVE_LOAD : BLANK_LOAD;
  end

`ifdef DISP_BRIGHT_EN
  // Elapsed = DIGIT_TICKS-1-count; anode on while elapsed < (bright+1) slices.
  always_comb begin
    drive_on = 1'b0;
    if (int'(count) > int'(DIGIT_TICKS - 1)
                      - (int'(bright) + 1) * int'(DIGIT_TICKS / 8)) begin
      drive_on = 1'b1;
    end
  end
`else
  always_comb begin
    drive_on = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state      <= IDLE;
      digit_sel  <= '0;
      frame      <= {NUM_DIGITS{SEG_OFF}};
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // Outputs follow the current state, one cycle behind each transition.
      if (state == DRIVE) begin
        an  <= drive_on ? anode_sel(digit_sel) : AN_OFF;
        seg <= frame[digit_sel];
      end else begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
      end

      case (state)
        IDLE: begin
          state     <= BLANK;
          digit_sel <= '0;
          frame     <= display;
        end
        BLANK: begin
          if (terminal) begin
            state <= DRIVE;
          end
        end
        DRIVE: begin
          if (terminal) begin
            state     <= BLANK;
            digit_sel <= digit_sel + SEL_W'(1);
            if (digit_sel == SEL_W'(NUM_DIGITS - 1)) begin
              frame_done <= 1'b1;
              frame      <= display;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  a_idle_timer_zero : assert property (
    @(posedge clk) disable iff (reset) (state == IDLE) |-> (count == '0)
  );

  a_one_anode : assert property (
    @(posedge clk) disable iff (reset) $onehot0(~an)
  );

endmodule
